// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=4 convolutional encoder with per-frame 3-bit zero tail so the trellis ends in state 0.
// Optional symbol error injection (err_idx/err_mask ports) is built when CONV_ERR_INJECT_EN is defined.
module conv_encoder_framer #(
    parameter int         FRAME_LEN = 16,
    parameter int         CW        = 8,
    parameter logic [3:0] G0        = 4'b1111,
    parameter logic [3:0] G1        = 4'b1101
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          din,
    input  logic          din_valid,
    output logic          din_ready,
`ifdef CONV_ERR_INJECT_EN
    input  logic [CW-1:0] err_idx,
    input  logic [1:0]    err_mask,
`endif
    output logic [1:0]    Rx,
    output logic          rx_valid,
    output logic          seqrdy,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

    localparam logic [CW-1:0] LAST_BIT_IDX = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAST_SYM_IDX = CW'(FRAME_LEN + 2);

    state_t        state;
    state_t        state_next;
    logic [2:0]    sr;
    logic [CW-1:0] sym_cnt;
    logic [1:0]    tail_cnt;
    logic          accept;
    logic          last_bit;
    logic          tail_end;
    logic          emit;
    logic          din_eff;
    logic [3:0]    tap_vec;
    logic [1:0]    sym_code;
    logic [1:0]    sym_out;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DATA;
            DATA:    if (accept && last_bit) state_next = TAIL;
            TAIL:    if (tail_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            DATA:    din_ready = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // TAIL spends cycles 0..2 emitting zero-input symbols; cycle 3 only shows the last one
    assign tail_end = (tail_cnt == 2'd3);
    assign accept   = din_valid & din_ready;
    assign last_bit = (sym_cnt == LAST_BIT_IDX);
    assign emit     = accept | ((state == TAIL) & ~tail_end);
    assign din_eff  = (state == DATA) & din;

    assign tap_vec  = {din_eff, sr};
    assign sym_code = {^(G0 & tap_vec), ^(G1 & tap_vec)};

`ifdef CONV_ERR_INJECT_EN
    assign sym_out = sym_code ^ ((sym_cnt == err_idx) ? err_mask : 2'b00);
`else
    assign sym_out = sym_code;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            sr       <= '0;
            sym_cnt  <= '0;
            tail_cnt <= '0;
            Rx       <= '0;
            rx_valid <= 1'b0;
            seqrdy   <= 1'b0;
        end else begin
            rx_valid <= emit;
            if (state == IDLE && start) begin
                sr       <= '0;
                sym_cnt  <= '0;
                tail_cnt <= '0;
            end
            if (emit) begin
                Rx     <= sym_out;
                sr     <= {din_eff, sr[2:1]};
                seqrdy <= 1'b1;
                if (sym_cnt != LAST_SYM_IDX) begin
                    sym_cnt <= sym_cnt + CW'(1);
                end
            end
            if (state == TAIL) begin
                if (tail_end) begin
                    seqrdy <= 1'b0;
                end else begin
                    tail_cnt <= tail_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer (FRAME_LEN=4): vector table, hand corner cases,
// and random frames against a tap-sum reference model; error-injection cases when CONV_ERR_INJECT_EN is defined.
module tb_conv_encoder_framer;

    localparam int         FL   = 4;
    localparam int         NSYM = FL + 3;
    localparam int         CW   = 8;
    localparam logic [3:0] G0   = 4'b1111;
    localparam logic [3:0] G1   = 4'b1101;

    typedef logic [0:NSYM-1][1:0] syms_t;

    typedef struct {
        logic [0:FL-1] bits;
        syms_t         syms;
    } vec_t;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic       din       = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [1:0] Rx;
    logic       rx_valid;
    logic       seqrdy;
    logic       busy;
    logic       frame_done;
`ifdef CONV_ERR_INJECT_EN
    logic [CW-1:0] err_idx  = '1;
    logic [1:0]    err_mask = 2'b00;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] sym_q[$];
    int         n_fd, n_seq, n_rise, first_c, last_c, n_acc, n_gap, n_pre, timed_out;
    bit         seq_prev;
    vec_t       tbl[5];

    always #5 clock = ~clock;

    conv_encoder_framer #(.FRAME_LEN(FL), .CW(CW), .G0(G0), .G1(G1)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
`ifdef CONV_ERR_INJECT_EN
        .err_idx    (err_idx),
        .err_mask   (err_mask),
`endif
        .Rx         (Rx),
        .rx_valid   (rx_valid),
        .seqrdy     (seqrdy),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Symbol k is the mod-2 sum of generator taps over input bits u[k], u[k-1], u[k-2], u[k-3]
    function automatic logic [1:0] model_symbol(input logic [0:FL-1] bits, input int k);
        int p0 = 0;
        int p1 = 0;
        for (int j = 0; j < 4; j++) begin
            int t = k - j;
            int u = 0;
            if (t >= 0 && t < FL) u = int'(bits[t]);
            p0 += int'(G0[3-j]) * u;
            p1 += int'(G1[3-j]) * u;
        end
        return {p0[0], p1[0]};
    endfunction

    function automatic syms_t model_frame(input logic [0:FL-1] bits);
        syms_t s;
        for (int k = 0; k < NSYM; k++) s[k] = model_symbol(bits, k);
        return s;
    endfunction

    task automatic sample_cycle(input int c);
        if (rx_valid) begin
            sym_q.push_back(Rx);
            if (first_c < 0) first_c = c;
            last_c = c;
        end
        if (seqrdy) begin
            n_seq++;
            if (!seq_prev) n_rise++;
        end
        seq_prev = seqrdy;
        if (frame_done) n_fd++;
    endtask

    // Runs one frame starting from IDLE and leaves the DUT in its first IDLE cycle afterwards
    task automatic apply_stimulus(input logic [0:FL-1] bits, input int stall_at, input int stall_len,
                                  input bit rand_stall, input bit poke);
        int idx     = 0;
        int stalled = 0;
        int c       = 0;
        bit ready_now;
        sym_q.delete();
        n_fd = 0; n_seq = 0; n_rise = 0; first_c = -1; last_c = -1;
        n_acc = 0; n_gap = 0; n_pre = 0; timed_out = 0; seq_prev = 1'b0;
        start = 1'b1; din_valid = poke; din = 1'b1;
        @(posedge clock); #1;
        start = poke;
        sample_cycle(c);
        while (n_fd == 0 && c < 100) begin
            c++;
            if (idx < FL) begin
                din = bits[idx];
                if (rand_stall) din_valid = ($urandom_range(0, 2) != 0);
                else if (idx == stall_at && stalled < stall_len) begin
                    din_valid = 1'b0;
                    stalled++;
                end else din_valid = 1'b1;
                if (!din_valid && idx == 0) n_pre++;
                if (!din_valid && idx > 0) n_gap++;
            end else begin
                din = 1'b1;
                din_valid = poke;
            end
            ready_now = din_ready;
            @(posedge clock); #1;
            if (ready_now && din_valid) begin
                idx++;
                n_acc++;
            end
            sample_cycle(c);
        end
        if (n_fd == 0) timed_out = 1;
        check_output("frame timeout", timed_out, 0);
        start = poke; din_valid = poke; din = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_output("frame_done width", int'(frame_done), 0);
        check_output("idle busy", int'(busy), 0);
        check_output("idle din_ready", int'(din_ready), 0);
        check_output("idle seqrdy", int'(seqrdy), 0);
        check_output("idle rx_valid", int'(rx_valid), 0);
        if (poke) begin
            din_valid = 1'b1;
            @(posedge clock); #1;
            check_output("idle din_valid ignored", int'(busy), 0);
        end
        din_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input syms_t exp);
        check_output($sformatf("%s symbol count", tag), sym_q.size(), NSYM);
        for (int k = 0; k < NSYM; k++)
            check_output($sformatf("%s sym%0d", tag, k),
                         (k < sym_q.size()) ? int'(sym_q[k]) : -1, int'(exp[k]));
        check_output($sformatf("%s frame_done count", tag), n_fd, 1);
        check_output($sformatf("%s bits accepted", tag), n_acc, FL);
        check_output($sformatf("%s seqrdy rises", tag), n_rise, 1);
        check_output($sformatf("%s seqrdy cycles", tag), n_seq, NSYM + n_gap);
        check_output($sformatf("%s first symbol cycle", tag), first_c, 1 + n_pre);
        check_output($sformatf("%s symbol span", tag), last_c - first_c + 1, NSYM + n_gap);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [0:FL-1] rbits;
        syms_t         exp;
        int            n_bad;

        tbl[0] = '{bits: 4'b1011, syms: {2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11}};
        tbl[1] = '{bits: 4'b0000, syms: {7{2'b00}}};
        tbl[2] = '{bits: 4'b1111, syms: {2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11}};
        tbl[3] = '{bits: 4'b1000, syms: {2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00}};
        tbl[4] = '{bits: 4'b0001, syms: {2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b11}};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset Rx", int'(Rx), 0);
        check_output("reset rx_valid", int'(rx_valid), 0);
        check_output("reset seqrdy", int'(seqrdy), 0);
        check_output("reset busy", int'(busy), 0);
        check_output("reset frame_done", int'(frame_done), 0);
        check_output("reset din_ready", int'(din_ready), 0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(tbl[i].bits, -1, 0, 1'b0, 1'b0);
            check_frame($sformatf("table%0d", i), tbl[i].syms);
        end

        apply_stimulus(tbl[0].bits, 2, 2, 1'b0, 1'b0);
        check_frame("stall", tbl[0].syms);
        check_output("stall seqrdy cycles const", n_seq, 9);

        apply_stimulus(tbl[0].bits, -1, 0, 1'b0, 1'b1);
        check_frame("poke", tbl[0].syms);

        start = 1'b1; din_valid = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din = tbl[0].bits[i]; din_valid = 1'b1;
            @(posedge clock); #1;
        end
        check_output("pre-reset rx_valid", int'(rx_valid), 1);
        check_output("pre-reset Rx", int'(Rx), 3);
        reset = 1'b0; din = tbl[0].bits[2];
        @(posedge clock); #1;
        check_output("mid reset Rx", int'(Rx), 0);
        check_output("mid reset rx_valid", int'(rx_valid), 0);
        check_output("mid reset seqrdy", int'(seqrdy), 0);
        check_output("mid reset busy", int'(busy), 0);
        check_output("mid reset frame_done", int'(frame_done), 0);
        check_output("mid reset din_ready", int'(din_ready), 0);
        reset = 1'b1; din_valid = 1'b0;
        n_bad = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (frame_done || busy || rx_valid) n_bad++;
        end
        check_output("after reset quiet", n_bad, 0);
        apply_stimulus(tbl[0].bits, -1, 0, 1'b0, 1'b0);
        check_frame("post-reset", tbl[0].syms);

        apply_stimulus(tbl[2].bits, -1, 0, 1'b0, 1'b0);
        check_frame("b2b first", tbl[2].syms);
        apply_stimulus(tbl[2].bits, -1, 0, 1'b0, 1'b0);
        check_frame("b2b second", tbl[2].syms);

        for (int r = 0; r < 25; r++) begin
            rbits = FL'($urandom);
            apply_stimulus(rbits, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
            check_frame($sformatf("rand%0d", r), model_frame(rbits));
        end

`ifdef CONV_ERR_INJECT_EN
        err_idx = 8'd2; err_mask = 2'b10;
        apply_stimulus(tbl[0].bits, -1, 0, 1'b0, 1'b0);
        exp = model_frame(tbl[0].bits);
        exp[2] = exp[2] ^ 2'b10;
        check_frame("inject idx2", exp);
        err_idx = 8'(NSYM); err_mask = 2'b11;
        apply_stimulus(tbl[2].bits, -1, 0, 1'b0, 1'b0);
        check_frame("inject out of range", model_frame(tbl[2].bits));
        err_idx = 8'd6; err_mask = 2'b01;
        rbits = FL'($urandom);
        apply_stimulus(rbits, -1, 0, 1'b1, 1'b0);
        exp = model_frame(rbits);
        exp[6] = exp[6] ^ 2'b01;
        check_frame("inject last tail", exp);
        err_idx = '1; err_mask = 2'b00;
`else
        exp = model_frame(tbl[0].bits);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
